// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared constants and helpers for the parametrised register file.
//   Contents:
//     DEFAULT_DATA_WIDTH / DEFAULT_ADDR_WIDTH - default geometry
//     REG_ZERO                                - the hardwired-zero register address
//     regDepth()                              - number of architectural registers
//   Optional feature macro used by the files importing this package:
//     REGFILE_BYPASS_EN (same-cycle write-to-read bypass)

package regfile_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;

  // Register 0 reads as zero, ignores writes and can never be claimed.
  localparam int REG_ZERO = 0;

  function automatic int regDepth(input int addrWidth);
    return 1 << addrWidth;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Busy-bit scoreboard for the register file. One busy bit per register
//   1..depth-1; issue claims a destination, writeback releases it, flush
//   squashes every outstanding claim.
//   Ports:
//     clk, resetN              - clock, asynchronous active-low reset
//     claimEn, claimAdrx       - mark claimAdrx busy
//     writeEn, writeAdrx       - writeback, releases the claim on writeAdrx
//     flush                    - clear every busy bit (claim ignored that cycle)
//     rdAdrx0/1 -> rdBusy0/1   - combinational busy read-out per read port
//     anyBusy                  - registered OR of all busy bits
//   Macro REGFILE_BYPASS_EN: a register being written this cycle reads as not
//   busy unless it is re-claimed in the same cycle.

module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  claimEn,
  input  logic [ADDR_WIDTH-1:0] claimAdrx,
  input  logic                  writeEn,
  input  logic [ADDR_WIDTH-1:0] writeAdrx,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] rdAdrx0,
  input  logic [ADDR_WIDTH-1:0] rdAdrx1,
  output logic                  rdBusy0,
  output logic                  rdBusy1,
  output logic                  anyBusy
);

  localparam int DEPTH = regDepth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADRX = ADDR_WIDTH'(REG_ZERO);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             anyBusy_q;
  logic             claimValid;
  logic             releaseValid;

  // Flush overrides the claim; a write still releases unless flushed anyway.
  assign claimValid   = claimEn && (claimAdrx != ZERO_ADRX) && !flush;
  assign releaseValid = writeEn && (writeAdrx != ZERO_ADRX);

  // Release is applied before the claim so a same-register claim wins:
  // a newer producer is in flight and must keep the bit set.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (releaseValid) busy_d[writeAdrx] = 1'b0;
      if (claimValid)   busy_d[claimAdrx] = 1'b1;
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      busy_q    <= '0;
      anyBusy_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      anyBusy_q <= |busy_d;
    end
  end

  assign anyBusy = anyBusy_q;

  // Bit 0 is held at zero, so address 0 naturally reads as not busy.
`ifdef REGFILE_BYPASS_EN
  assign rdBusy0 = (releaseValid && (writeAdrx == rdAdrx0) &&
                    !(claimValid && (claimAdrx == rdAdrx0))) ? 1'b0 : busy_q[rdAdrx0];
  assign rdBusy1 = (releaseValid && (writeAdrx == rdAdrx1) &&
                    !(claimValid && (claimAdrx == rdAdrx1))) ? 1'b0 : busy_q[rdAdrx1];
`else
  assign rdBusy0 = busy_q[rdAdrx0];
  assign rdBusy1 = busy_q[rdAdrx1];
`endif

endmodule

// File: rtl/param_register_file.sv
// param_register_file
//   Two-read/one-write register file with busy-bit scoreboard.
//   Ports:
//     clk, resetN                      - clock, asynchronous active-low reset
//     rdAdrx0/1 -> rdData0/1, rdBusy0/1 - combinational read ports
//     writeEn, writeAdrx, writeData    - writeback (also releases the claim)
//     claimEn, claimAdrx               - issue-time destination claim
//     flush                            - clear all busy bits
//     anyBusy                          - any claim outstanding (post-edge)
//   Macro REGFILE_BYPASS_EN: writeback data is forwarded to a read port
//   addressing the same register in the same cycle.

module param_register_file
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic [ADDR_WIDTH-1:0] rdAdrx0,
  input  logic [ADDR_WIDTH-1:0] rdAdrx1,
  output logic [DATA_WIDTH-1:0] rdData0,
  output logic [DATA_WIDTH-1:0] rdData1,
  output logic                  rdBusy0,
  output logic                  rdBusy1,
  input  logic                  writeEn,
  input  logic [ADDR_WIDTH-1:0] writeAdrx,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  claimEn,
  input  logic [ADDR_WIDTH-1:0] claimAdrx,
  input  logic                  flush,
  output logic                  anyBusy
);

  localparam int DEPTH = regDepth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADRX = ADDR_WIDTH'(REG_ZERO);

  // Entry 0 is never written and stays at its reset value; the read muxes
  // also force zero for address 0, so it folds away in synthesis.
  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic                  writeValid;

  assign writeValid = writeEn && (writeAdrx != ZERO_ADRX);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      regs_q <= '{default: '0};
    end else if (writeValid) begin
      regs_q[writeAdrx] <= writeData;
    end
  end

  // Forwarding is gated by resetN so the read ports stay at zero in reset.
  always_comb begin
    rdData0 = regs_q[rdAdrx0];
    if (rdAdrx0 == ZERO_ADRX) begin
      rdData0 = '0;
`ifdef REGFILE_BYPASS_EN
    end else if (resetN && writeValid && (writeAdrx == rdAdrx0)) begin
      rdData0 = writeData;
`endif
    end
  end

  always_comb begin
    rdData1 = regs_q[rdAdrx1];
    if (rdAdrx1 == ZERO_ADRX) begin
      rdData1 = '0;
`ifdef REGFILE_BYPASS_EN
    end else if (resetN && writeValid && (writeAdrx == rdAdrx1)) begin
      rdData1 = writeData;
`endif
    end
  end

  reg_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) uScoreboard (
    .clk      (clk),
    .resetN   (resetN),
    .claimEn  (claimEn),
    .claimAdrx(claimAdrx),
    .writeEn  (writeEn),
    .writeAdrx(writeAdrx),
    .flush    (flush),
    .rdAdrx0  (rdAdrx0),
    .rdAdrx1  (rdAdrx1),
    .rdBusy0  (rdBusy0),
    .rdBusy1  (rdBusy1),
    .anyBusy  (anyBusy)
  );

endmodule

// File: tb/tb_param_register_file.sv
// tb_param_register_file
//   Directed bench for param_register_file with a behavioural reference
//   model (plain arrays) checked every cycle, plus literal expectations.
//   Honours REGFILE_BYPASS_EN in the same way as the design.

module tb_param_register_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NREG = 1 << AW;

  logic          clk;
  logic          resetN;
  logic [AW-1:0] rdAdrx0, rdAdrx1, writeAdrx, claimAdrx;
  logic [DW-1:0] rdData0, rdData1, writeData;
  logic          rdBusy0, rdBusy1, writeEn, claimEn, flush, anyBusy;

  int testsRun = 0;
  int testsFailed = 0;

  // Reference state: what the register file should hold after each edge.
  logic [DW-1:0] mReg  [NREG];
  logic          mBusy [NREG];
  logic          mAny;

  param_register_file #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk      (clk),
    .resetN   (resetN),
    .rdAdrx0  (rdAdrx0),
    .rdAdrx1  (rdAdrx1),
    .rdData0  (rdData0),
    .rdData1  (rdData1),
    .rdBusy0  (rdBusy0),
    .rdBusy1  (rdBusy1),
    .writeEn  (writeEn),
    .writeAdrx(writeAdrx),
    .writeData(writeData),
    .claimEn  (claimEn),
    .claimAdrx(claimAdrx),
    .flush    (flush),
    .anyBusy  (anyBusy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model update follows the architectural rules: flush clears everything,
  // otherwise a write releases and a claim sets, with the claim taking
  // precedence on the same register.
  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NREG; i++) begin
        mReg[i]  = '0;
        mBusy[i] = 1'b0;
      end
      mAny = 1'b0;
    end else begin
      if (writeEn && writeAdrx != 0) mReg[writeAdrx] = writeData;
      if (flush) begin
        for (int i = 0; i < NREG; i++) mBusy[i] = 1'b0;
      end else begin
        if (writeEn && writeAdrx != 0) mBusy[writeAdrx] = 1'b0;
        if (claimEn && claimAdrx != 0) mBusy[claimAdrx] = 1'b1;
      end
      mAny = 1'b0;
      for (int i = 1; i < NREG; i++) mAny = mAny | mBusy[i];
    end
  end

  function automatic logic [DW-1:0] expData(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (resetN && writeEn && writeAdrx == a) return writeData;
`endif
    return mReg[a];
  endfunction

  function automatic logic expBusy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (writeEn && writeAdrx == a && !(claimEn && claimAdrx == a && !flush))
      return 1'b0;
`endif
    return mBusy[a];
  endfunction

  // Mid-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("model rdData0", rdData0, expData(rdAdrx0));
      checkOutput("model rdData1", rdData1, expData(rdAdrx1));
      checkOutput("model rdBusy0", DW'(rdBusy0), DW'(expBusy(rdAdrx0)));
      checkOutput("model rdBusy1", DW'(rdBusy1), DW'(expBusy(rdAdrx1)));
      checkOutput("model anyBusy", DW'(anyBusy), DW'(mAny));
    end
  end

  // Drives one cycle of inputs shortly after the rising edge, then waits
  // for mid-cycle so literal checks see that cycle's outputs.
  task automatic applyStimulus(input logic we, input logic [AW-1:0] wa,
                               input logic [DW-1:0] wd, input logic ce,
                               input logic [AW-1:0] ca, input logic fl,
                               input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    @(posedge clk);
    #1;
    writeEn = we; writeAdrx = wa; writeData = wd;
    claimEn = ce; claimAdrx = ca; flush = fl;
    rdAdrx0 = ra0; rdAdrx1 = ra1;
    @(negedge clk);
    #1;
  endtask

  initial begin
    resetN = 1'b0;
    writeEn = 1'b0; writeAdrx = '0; writeData = '0;
    claimEn = 1'b0; claimAdrx = '0; flush = 1'b0;
    rdAdrx0 = '0; rdAdrx1 = '0;
    repeat (3) @(posedge clk);
    #1 resetN = 1'b1;

    // Reset state
    applyStimulus(0, 0, 0, 0, 0, 0, 5, 7);
    checkOutput("reset rdData0", rdData0, 32'h0);
    checkOutput("reset anyBusy", DW'(anyBusy), 32'h0);

    // Write reg 5, read next cycle, then asynchronous reset mid-run
    applyStimulus(1, 5, 32'hDEADBEEF, 1, 5, 0, 5, 5);
    applyStimulus(0, 0, 0, 0, 0, 0, 5, 5);
    checkOutput("reg5 written", rdData0, 32'hDEADBEEF);
    checkOutput("reg5 claim kept", DW'(rdBusy0), 32'h1);
    @(posedge clk);
    #1 resetN = 1'b0;
    #2;
    checkOutput("in reset rdData0", rdData0, 32'h0);
    checkOutput("in reset anyBusy", DW'(anyBusy), 32'h0);
    checkOutput("in reset rdBusy0", DW'(rdBusy0), 32'h0);
    @(posedge clk);
    #1 resetN = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 5, 0);
    checkOutput("after reset rdData0", rdData0, 32'h0);
    checkOutput("after reset anyBusy", DW'(anyBusy), 32'h0);

    // Plain write/read and the hardwired zero register
    applyStimulus(1, 7, 32'h12345678, 0, 0, 0, 0, 7);
    applyStimulus(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 7);
    checkOutput("reg7 read", rdData1, 32'h12345678);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 7);
    checkOutput("reg0 reads zero", rdData0, 32'h0);
    checkOutput("reg0 claim ignored", DW'(anyBusy), 32'h0);

    // Claim then release reg 3
    applyStimulus(0, 0, 0, 1, 3, 0, 3, 0);
    applyStimulus(0, 0, 0, 1, 3, 0, 3, 0);
    checkOutput("claim3 busy", DW'(rdBusy0), 32'h1);
    checkOutput("claim3 anyBusy", DW'(anyBusy), 32'h1);
    applyStimulus(1, 3, 32'hA5, 0, 0, 0, 3, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 3, 0);
    checkOutput("release3 busy", DW'(rdBusy0), 32'h0);
    checkOutput("release3 data", rdData0, 32'hA5);
    checkOutput("release3 anyBusy", DW'(anyBusy), 32'h0);

    // Write to a register that is not busy
    applyStimulus(1, 12, 32'h0000C0DE, 0, 0, 0, 12, 12);
    applyStimulus(0, 0, 0, 0, 0, 0, 12, 12);
    checkOutput("unclaimed write data", rdData1, 32'h0000C0DE);
    checkOutput("unclaimed write busy", DW'(rdBusy1), 32'h0);

    // Simultaneous claim and write on reg 9: claim wins
    applyStimulus(1, 9, 32'h99, 1, 9, 0, 2, 9);
    applyStimulus(0, 0, 0, 1, 2, 0, 2, 9);
    checkOutput("claim+write9 busy", DW'(rdBusy1), 32'h1);
    checkOutput("claim+write9 data", rdData1, 32'h99);
    applyStimulus(0, 0, 0, 1, 2, 0, 2, 9);
    checkOutput("claim2 busy", DW'(rdBusy0), 32'h1);

    // Flush with a claim of reg 4: everything clear, write still lands
    applyStimulus(1, 6, 32'h66, 1, 4, 1, 4, 9);
    applyStimulus(0, 0, 0, 0, 0, 0, 4, 9);
    checkOutput("flush reg4 busy", DW'(rdBusy0), 32'h0);
    checkOutput("flush reg9 busy", DW'(rdBusy1), 32'h0);
    checkOutput("flush anyBusy", DW'(anyBusy), 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 6, 2);
    checkOutput("flush write lands", rdData0, 32'h66);
    checkOutput("flush reg2 busy", DW'(rdBusy1), 32'h0);

    // Bypass scenario on reg 3 (claimed, then written while being read)
    applyStimulus(0, 0, 0, 1, 3, 0, 3, 3);
    applyStimulus(1, 3, 32'h55, 0, 0, 0, 3, 3);
`ifdef REGFILE_BYPASS_EN
    checkOutput("bypass same-cycle data", rdData0, 32'h55);
    checkOutput("bypass same-cycle busy", DW'(rdBusy0), 32'h0);
`else
    checkOutput("no-bypass same-cycle data", rdData0, 32'hA5);
    checkOutput("no-bypass same-cycle busy", DW'(rdBusy0), 32'h1);
`endif
    applyStimulus(0, 0, 0, 0, 0, 0, 3, 3);
    checkOutput("after write3 data", rdData0, 32'h55);
    checkOutput("after write3 busy", DW'(rdBusy0), 32'h0);

    // Idempotent double claim, then a re-claim while writing the same register
    applyStimulus(0, 0, 0, 1, 31, 0, 31, 30);
    applyStimulus(0, 0, 0, 1, 31, 0, 31, 30);
    applyStimulus(1, 31, 32'hFEEDF00D, 1, 31, 0, 31, 31);
    checkOutput("reclaim same-cycle busy", DW'(rdBusy1), 32'h1);
    applyStimulus(1, 31, 32'h31313131, 0, 0, 0, 31, 30);
    applyStimulus(0, 0, 0, 0, 0, 0, 31, 30);
    checkOutput("reg31 final data", rdData0, 32'h31313131);
    checkOutput("reg31 final anyBusy", DW'(anyBusy), 32'h0);

    // A few mixed cycles for the per-cycle model
    for (int i = 1; i < 8; i++) begin
      applyStimulus(1'(i % 2), AW'(i + 8), DW'(i * 32'h01010101), 1'(i % 3 == 0),
                    AW'(i + 9), 1'(i == 6), AW'(i + 8), AW'(i + 9));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
